// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix, F-keys and modifiers.
// Ports: clk_sys, reset (async, high), ps2_kbd_clk/ps2_kbd_data (async PS/2),
//   addr (row select on [15:8], active-low), key_data (active-low columns),
//   Fn[11:1] (held F-keys), mod (Ctrl, Alt, GUI held).
module ps2_zx_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // held bits: 0..39 matrix (row*5+col), 40..44 compound keys,
  // 45..55 F1..F11, 56..61 LCtrl RCtrl LAlt RAlt LGui RGui
  localparam int NK = 62;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } state_t;

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_fclk;
  logic [FW-1:0] r_fcnt;
  logic          r_strobe;
  logic          r_sdat;

  state_t        r_state;
  logic [3:0]    r_bitcnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tmo;
  logic          r_bv;
  logic [7:0]    r_code;

  logic          r_ext;
  logic          r_brk;
  logic [NK-1:0] r_held;

  logic          w_frame_ok;
  logic          w_hit;
  logic [5:0]    w_idx;
  logic          w_ign;
  logic [39:0]   w_mat;
  logic [4:0]    w_col;
  logic          w_unused_addr;

  assign w_unused_addr = ^addr[7:0];

  // 2-FF synchronisers; lines idle high
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_kbd_clk};
      r_dat_s <= {r_dat_s[0], ps2_kbd_data};
    end
  end

  // Clock filter: level flips only after FILTER_LEN differing samples
  // in a row; a 1->0 flip is a bit strobe and captures the data line.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_fclk   <= 1'b1;
      r_fcnt   <= '0;
      r_strobe <= 1'b0;
      r_sdat   <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      if (r_clk_s[1] == r_fclk) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fclk   <= r_clk_s[1];
        r_fcnt   <= '0;
        r_strobe <= r_fclk;
        r_sdat   <= r_dat_s[1];
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // r_shift after 10 strobes: [9] stop, [8] parity, [7:0] data
  assign w_frame_ok = (^r_shift[8:0]) & r_shift[9];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tmo    <= '0;
      r_bv     <= 1'b0;
      r_code   <= '0;
    end else begin
      r_bv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_strobe && !r_sdat) begin
            r_state  <= S_SHIFT;
            r_bitcnt <= '0;
            r_tmo    <= '0;
          end
        end
        S_SHIFT: begin
          if (r_strobe) begin
            r_shift <= {r_sdat, r_shift[9:1]};
            r_tmo   <= '0;
            if (r_bitcnt == 4'd9) begin
              r_state <= S_CHECK;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else if (r_tmo == TW'(TIMEOUT)) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CHECK: begin
          r_bv    <= w_frame_ok;
          r_code  <= r_shift[7:0];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scancode to held-bit index; top bit of the key is the E0 flag
  always_comb begin
    w_hit = 1'b1;
    w_idx = '0;
    case ({r_ext, r_code})
      9'h012: w_idx = 6'd0;
      9'h01A: w_idx = 6'd1;
      9'h022: w_idx = 6'd2;
      9'h021: w_idx = 6'd3;
      9'h02A: w_idx = 6'd4;
      9'h01C: w_idx = 6'd5;
      9'h01B: w_idx = 6'd6;
      9'h023: w_idx = 6'd7;
      9'h02B: w_idx = 6'd8;
      9'h034: w_idx = 6'd9;
      9'h015: w_idx = 6'd10;
      9'h01D: w_idx = 6'd11;
      9'h024: w_idx = 6'd12;
      9'h02D: w_idx = 6'd13;
      9'h02C: w_idx = 6'd14;
      9'h016: w_idx = 6'd15;
      9'h01E: w_idx = 6'd16;
      9'h026: w_idx = 6'd17;
      9'h025: w_idx = 6'd18;
      9'h02E: w_idx = 6'd19;
      9'h045: w_idx = 6'd20;
      9'h046: w_idx = 6'd21;
      9'h03E: w_idx = 6'd22;
      9'h03D: w_idx = 6'd23;
      9'h036: w_idx = 6'd24;
      9'h04D: w_idx = 6'd25;
      9'h044: w_idx = 6'd26;
      9'h043: w_idx = 6'd27;
      9'h03C: w_idx = 6'd28;
      9'h035: w_idx = 6'd29;
      9'h05A: w_idx = 6'd30;
      9'h04B: w_idx = 6'd31;
      9'h042: w_idx = 6'd32;
      9'h03B: w_idx = 6'd33;
      9'h033: w_idx = 6'd34;
      9'h029: w_idx = 6'd35;
      9'h059: w_idx = 6'd36;
      9'h03A: w_idx = 6'd37;
      9'h031: w_idx = 6'd38;
      9'h032: w_idx = 6'd39;
      9'h066: w_idx = 6'd40;
      9'h16B: w_idx = 6'd41;
      9'h174: w_idx = 6'd42;
      9'h175: w_idx = 6'd43;
      9'h172: w_idx = 6'd44;
      9'h005: w_idx = 6'd45;
      9'h006: w_idx = 6'd46;
      9'h004: w_idx = 6'd47;
      9'h00C: w_idx = 6'd48;
      9'h003: w_idx = 6'd49;
      9'h00B: w_idx = 6'd50;
      9'h083: w_idx = 6'd51;
      9'h00A: w_idx = 6'd52;
      9'h001: w_idx = 6'd53;
      9'h009: w_idx = 6'd54;
      9'h078: w_idx = 6'd55;
      9'h014: w_idx = 6'd56;
      9'h114: w_idx = 6'd57;
      9'h011: w_idx = 6'd58;
      9'h111: w_idx = 6'd59;
      9'h11F: w_idx = 6'd60;
      9'h127: w_idx = 6'd61;
      default: w_hit = 1'b0;
    endcase
  end

  // keyboard status replies, only dropped when no prefix is pending
  assign w_ign = r_code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_held <= '0;
    end else if (r_bv) begin
      if (r_code == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_code == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (r_code == 8'hE1) begin
        r_ext <= r_ext;
      end else if (!r_ext && !r_brk && w_ign) begin
        r_ext <= r_ext;
      end else begin
        for (int i = 0; i < NK; i++) begin
          if (w_hit && w_idx == 6'(i)) begin
            r_held[i] <= ~r_brk;
          end
        end
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // Compound keys OR into CapsShift and their digit so each source
  // releases independently.
  always_comb begin
    w_mat     = r_held[39:0];
    w_mat[0]  = r_held[0] | (|r_held[44:40]);
    w_mat[20] = r_held[20] | r_held[40];
    w_mat[19] = r_held[19] | r_held[41];
    w_mat[22] = r_held[22] | r_held[42];
    w_mat[23] = r_held[23] | r_held[43];
    w_mat[24] = r_held[24] | r_held[44];
    w_col = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!addr[8+r]) begin
          w_col[c] = w_col[c] | w_mat[r*5+c];
        end
      end
    end
  end

  assign key_data = ~w_col;
  assign Fn       = r_held[55:45];
  assign mod      = {r_held[61] | r_held[60],
                     r_held[59] | r_held[58],
                     r_held[57] | r_held[56]};

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: vector table, corner sequences,
// random key traffic against a key-table model.
module tb_ps2_zx_keyboard;

  localparam int HB = 16;
  localparam int TO = 1000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [15:0] addr;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_zx_keyboard #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .addr        (addr),
    .key_data    (key_data),
    .Fn          (Fn),
    .mod         (mod)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         r1, c1, r2, c2;
    int         fn;
    int         md;
    bit         held;
  } ent_t;

  ent_t ents[$];
  bit   m_ext, m_brk;

  logic [7:0] mcodes [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h59, 8'h3A, 8'h31, 8'h32};
  logic [7:0] fcodes [11] = '{
    8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
    8'h83, 8'h0A, 8'h01, 8'h09, 8'h78};
  logic [7:0] junk [4] = '{8'h76, 8'h0D, 8'h58, 8'h7E};

  function automatic void add(bit e, logic [7:0] cd, int r1, int c1,
                              int r2, int c2, int fn, int md);
    ent_t t;
    t.ext = e; t.code = cd; t.r1 = r1; t.c1 = c1;
    t.r2 = r2; t.c2 = c2; t.fn = fn; t.md = md; t.held = 0;
    ents.push_back(t);
  endfunction

  function automatic void m_reset();
    foreach (ents[i]) ents[i].held = 0;
    m_ext = 0;
    m_brk = 0;
  endfunction

  function automatic void m_byte(logic [7:0] cd);
    if (cd == 8'hE0) m_ext = 1;
    else if (cd == 8'hF0) m_brk = 1;
    else if (cd == 8'hE1) m_ext = m_ext;
    else if (!m_ext && !m_brk &&
             (cd == 8'hAA || cd == 8'hFA || cd == 8'hEE ||
              cd == 8'hFE || cd == 8'hFF)) m_ext = m_ext;
    else begin
      foreach (ents[i])
        if (ents[i].ext == m_ext && ents[i].code == cd)
          ents[i].held = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic logic [4:0] m_kd(logic [15:0] a);
    logic [4:0] kd = 5'h1F;
    foreach (ents[i]) if (ents[i].held) begin
      if (ents[i].r1 >= 0 && !a[8+ents[i].r1]) kd[ents[i].c1] = 1'b0;
      if (ents[i].r2 >= 0 && !a[8+ents[i].r2]) kd[ents[i].c2] = 1'b0;
    end
    return kd;
  endfunction

  function automatic logic [11:1] m_fn();
    logic [11:1] f = '0;
    foreach (ents[i]) if (ents[i].held && ents[i].fn > 0) f[ents[i].fn] = 1'b1;
    return f;
  endfunction

  function automatic logic [2:0] m_mod();
    logic [2:0] m = '0;
    foreach (ents[i]) if (ents[i].held && ents[i].md >= 0) m[ents[i].md] = 1'b1;
    return m;
  endfunction

  // ---------------- drivers / checker ----------------
  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic ps2_bit(logic b);
    ps2_kbd_data = b;
    repeat (HB) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (HB) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_raw(logic [7:0] cd, bit badpar, bit badstop, int nbits);
    logic [10:0] b;
    b = {~badstop, (~^cd) ^ badpar, cd, 1'b0};
    @(negedge clk_sys);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_kbd_data = 1'b1;
    repeat (3 * HB) @(negedge clk_sys);
  endtask

  task automatic send(logic [7:0] cd);
    send_raw(cd, 1'b0, 1'b0, 11);
    m_byte(cd);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [31:0] b;
    int          n;
    logic [15:0] a;
    logic [4:0]  kd;
    logic [11:1] fn;
    logic [2:0]  md;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(logic [31:0] b, int n, logic [15:0] a,
                               logic [4:0] kd, logic [11:1] fn, logic [2:0] md);
    vec_t v;
    v.b = b; v.n = n; v.a = a; v.kd = kd; v.fn = fn; v.md = md;
    vt.push_back(v);
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cd;
    bit e, brk;
    int k;
    logic [10:0] gb;

    reset = 1'b1;
    ps2_kbd_clk = 1'b1;
    ps2_kbd_data = 1'b1;
    addr = 16'h00FE;

    for (int i = 0; i < 40; i++) add(0, mcodes[i], i / 5, i % 5, -1, -1, 0, -1);
    add(0, 8'h66, 0, 0, 4, 0, 0, -1);
    add(1, 8'h6B, 0, 0, 3, 4, 0, -1);
    add(1, 8'h74, 0, 0, 4, 2, 0, -1);
    add(1, 8'h75, 0, 0, 4, 3, 0, -1);
    add(1, 8'h72, 0, 0, 4, 4, 0, -1);
    for (int i = 0; i < 11; i++) add(0, fcodes[i], -1, -1, -1, -1, i + 1, -1);
    add(0, 8'h14, -1, -1, -1, -1, 0, 0);
    add(1, 8'h14, -1, -1, -1, -1, 0, 0);
    add(0, 8'h11, -1, -1, -1, -1, 0, 1);
    add(1, 8'h11, -1, -1, -1, -1, 0, 1);
    add(1, 8'h1F, -1, -1, -1, -1, 0, 2);
    add(1, 8'h27, -1, -1, -1, -1, 0, 2);
    m_reset();

    addv(32'h1C,     1, 16'hFDFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h1CF0,   2, 16'hFDFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h12,     1, 16'hFEFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h6BE0,   2, 16'hFEFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h0,      0, 16'hF7FE, 5'b01111, 11'h000, 3'b000);
    addv(32'h6BF0E0, 3, 16'hF7FE, 5'b11111, 11'h000, 3'b000);
    addv(32'h0,      0, 16'hFEFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h12F0,   2, 16'hFEFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h7811,   2, 16'hFFFE, 5'b11111, 11'h400, 3'b010);
    addv(32'h78F0,   2, 16'hFFFE, 5'b11111, 11'h000, 3'b010);
    addv(32'h11F0,   2, 16'hFFFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h1615,   2, 16'hF3FE, 5'b11110, 11'h000, 3'b000);
    addv(32'h0,      0, 16'hFFFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h15F0,   2, 16'hF3FE, 5'b11110, 11'h000, 3'b000);
    addv(32'h16F0,   2, 16'hF3FE, 5'b11111, 11'h000, 3'b000);
    addv(32'h66,     1, 16'hFEFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h0,      0, 16'hEFFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h66F0,   2, 16'hEFFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h14E0,   2, 16'hFFFF, 5'b11111, 11'h000, 3'b001);
    addv(32'h1FE0,   2, 16'hFFFF, 5'b11111, 11'h000, 3'b101);
    addv(32'h14F0E0, 3, 16'hFFFF, 5'b11111, 11'h000, 3'b100);
    addv(32'h1FF0E0, 3, 16'hFFFF, 5'b11111, 11'h000, 3'b000);
    addv(32'h05,     1, 16'h00FE, 5'b11111, 11'h001, 3'b000);
    addv(32'h05F0,   2, 16'h00FE, 5'b11111, 11'h000, 3'b000);
    addv(32'h1C1C,   2, 16'hFDFE, 5'b11110, 11'h000, 3'b000);
    addv(32'h1CF0,   2, 16'hFDFE, 5'b11111, 11'h000, 3'b000);
    addv(32'h2EF0,   2, 16'hF7FE, 5'b11111, 11'h000, 3'b000);
    addv(32'h5929,   2, 16'h7FFE, 5'b11100, 11'h000, 3'b000);
    addv(32'h59F029F0, 4, 16'h7FFE, 5'b11111, 11'h000, 3'b000);

    repeat (4) @(negedge clk_sys);
    #1;
    chk("rst_kd", 16'(key_data), 16'h1F);
    chk("rst_fn", 16'(Fn), 16'h0);
    chk("rst_mod", 16'(mod), 16'h0);
    @(negedge clk_sys);
    reset = 1'b0;

    foreach (vt[i]) begin
      for (int j = 0; j < vt[i].n; j++) send(vt[i].b[8*j +: 8]);
      addr = vt[i].a;
      #1;
      chk($sformatf("vec%0d_kd", i), 16'(key_data), 16'(vt[i].kd));
      chk($sformatf("vec%0d_fn", i), 16'(Fn), 16'(vt[i].fn));
      chk($sformatf("vec%0d_mod", i), 16'(mod), 16'(vt[i].md));
    end

    // bad frames
    addr = 16'hFDFE;
    send_raw(8'h1C, 1'b1, 1'b0, 11);
    #1 chk("parity_err", 16'(key_data), 16'h1F);
    send_raw(8'h1C, 1'b0, 1'b1, 11);
    #1 chk("stop_err", 16'(key_data), 16'h1F);

    // truncated frame then timeout
    send_raw(8'h1C, 1'b0, 1'b0, 7);
    repeat (TO + 100) @(negedge clk_sys);
    send(8'h1C);
    #1 chk("after_timeout", 16'(key_data), 16'h1E);
    send(8'hF0);
    send(8'h1C);
    #1 chk("timeout_rel", 16'(key_data), 16'h1F);

    // short clock glitches carrying a 1C frame
    gb = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_kbd_data = gb[i];
      repeat (HB) @(negedge clk_sys);
      ps2_kbd_clk = 1'b0;
      repeat (5) @(negedge clk_sys);
      ps2_kbd_clk = 1'b1;
      repeat (HB) @(negedge clk_sys);
    end
    ps2_kbd_data = 1'b1;
    repeat (3 * HB) @(negedge clk_sys);
    #1 chk("glitch", 16'(key_data), 16'h1F);
    send(8'h1C);
    #1 chk("post_glitch", 16'(key_data), 16'h1E);
    send(8'hF0);
    send(8'h1C);

    // reset mid-frame with E0 pending
    send(8'hE0);
    send_raw(8'h1C, 1'b0, 1'b0, 5);
    do_reset();
    send(8'h6B);
    addr = 16'hFEFE;
    #1 chk("rst_clr_ext", 16'(key_data), 16'(m_kd(addr)));
    send(8'h1C);
    addr = 16'hFDFE;
    #1 chk("rst_midframe", 16'(key_data), 16'h1E);

    // asynchronous reset with keys held
    send(8'h78);
    send(8'h11);
    #1 chk("pre_async_fn", 16'(Fn), 16'h400);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("async_kd", 16'(key_data), 16'h1F);
    chk("async_fn", 16'(Fn), 16'h0);
    chk("async_mod", 16'(mod), 16'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    m_reset();

    // random traffic against the model
    for (int ev = 0; ev < 30; ev++) begin
      k = $urandom_range(0, ents.size() + 3);
      if (k < ents.size()) begin
        e = ents[k].ext;
        cd = ents[k].code;
      end else begin
        e = 1'($urandom % 2);
        cd = junk[k - ents.size()];
      end
      brk = 1'($urandom % 2);
      if ($urandom % 8 == 0) send(8'hE1);
      if ($urandom % 8 == 0) send(8'hAA);
      if (e) send(8'hE0);
      if (brk) send(8'hF0);
      send(cd);
      for (int q = 0; q < 3; q++) begin
        addr = {8'($urandom), 8'($urandom)};
        #1 chk($sformatf("rnd%0d_kd", ev), 16'(key_data), 16'(m_kd(addr)));
      end
      chk($sformatf("rnd%0d_fn", ev), 16'(Fn), 16'(m_fn()));
      chk($sformatf("rnd%0d_mod", ev), 16'(mod), 16'(m_mod()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_zx_keyboard.md
Name: ps2_zx_keyboard

Overview:
- Sits directly upstream of the Spectrum top level.
- Receives PS/2 keyboard frames from the ARM I/O block and decodes set-2 scancodes, including E0/F0 prefixes.
- Maintains an 8x5 ZX key matrix plus function-key and modifier state.
- Answers ULA port-FE reads with the active-low column data for the rows selected by addr[15:8].

Parameters:
- FILTER_LEN, 8: clk_sys cycles ps2_kbd_clk must hold a new level before the edge is accepted.
- TIMEOUT, 65535: clk_sys cycles without a falling clock edge mid-frame before the receiver aborts to idle.

Ports:
- clk_sys  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_kbd_clk  in  1  PS/2 clock, asynchronous.
- ps2_kbd_data  in  1  PS/2 data, asynchronous.
- addr  in  16  CPU address; addr[15:8] selects rows, active-low.
- key_data  out  5  column data, active-low (bit0 = outermost key).
- Fn  out  11  Fn[i] = 1 while F(i) is held, i = 1..11.
- mod  out  3  held modifiers: [0] Ctrl (L/R), [1] Alt (L/R), [2] GUI/Win (L/R).

Behaviour:

Reset:
- Reset is asynchronous, active-high.
- All matrix bits released, Fn = 0, mod = 0, receiver idle, prefix flags cleared.
- key_data therefore reads 5'b11111.

Input synchroniser and filter:
- Both PS/2 lines pass through 2-FF synchronisers.
- A filtered clock level changes only after FILTER_LEN consecutive equal samples.
- A falling edge of the filtered clock is a bit strobe.

Receiver FSM:
- States: IDLE, SHIFT, CHECK.
- IDLE: a strobe with data 0 (start bit) moves to SHIFT with bitcnt = 0.
- SHIFT: each strobe shifts data in LSB-first. After 8 data bits + parity + stop (bitcnt = 9 consumed), go to CHECK.
- CHECK (one cycle): frame is valid if the 8 data bits plus parity have odd parity and stop = 1.
  - Valid: raise a one-cycle byte_valid with the code.
  - Invalid: discard the frame, no state change.
  - Always return to IDLE.
- A strobe in IDLE with data 1 is ignored.
- In SHIFT, a timeout counter reloads on each strobe. At TIMEOUT it aborts to IDLE and discards the partial frame.

Decoder (acts on byte_valid):
- E0: set ext flag. F0: set brk flag. E1: ignored, no flag change.
- Any other code:
  - apply make (brk = 0) or release (brk = 1) to the mapped target;
  - then clear ext and brk;
  - unmapped codes only clear the flags.
- Codes AA/FA/EE/FE/FF arriving with no prefix pending are ignored.

Matrix (row r selected when addr[8+r] = 0; columns listed bit0..bit4):
- r0: CapsShift Z X C V
- r1: A S D F G
- r2: Q W E R T
- r3: 1 2 3 4 5
- r4: 0 9 8 7 6
- r5: P O I U Y
- r6: Enter L K J H
- r7: Space SymShift M N B
- PC letters, digits, Enter and Space map by name.
- Left Shift maps to CapsShift. Right Shift maps to SymShift.
- Backspace maps to CapsShift + 0.
- Arrows (E0-prefixed) map to CapsShift + 5/8/7/6 for Left/Right/Up/Down.
- Compound keys own a private held bit. Their CapsShift contribution is ORed with the other CapsShift sources, so releasing an arrow never releases a physically held Left Shift.
- key_data is combinational: bit c = NOT (OR over selected rows of key[r][c]).
  - No row selected gives 11111.
  - Multiple rows selected are ANDed (active-low).

Function keys and modifiers:
- F1..F11 scancodes: 05, 06, 04, 0C, 03, 0B, 83, 0A, 01, 09, 78. Each maps to Fn[1..11].
- Ctrl (14 and E0 14), Alt (11 and E0 11) and GUI (E0 1F / E0 27) drive mod, with L/R tracked separately and ORed.

Timing and boundaries:
- Latency: a key bit updates on the clk_sys edge after CHECK, i.e. 2 cycles after the stop-bit strobe is filtered.
- Repeated make codes (typematic) are idempotent.
- A release with no prior make is harmless.
- Reset mid-frame returns to IDLE and clears prefix flags.
- Line noise shorter than FILTER_LEN cycles never produces a strobe.

Test Plan:
- Send a valid frame for code 1C (A) with addr = 16'hFDFE → key_data = 5'b11110. Then send F0 1C → key_data = 5'b11111.
- Send 12, then E0 6B (LeftShift, Left arrow), addr = 16'hFEFE → bit0 = 0. Release the arrow (E0 F0 6B) → bit0 stays 0. With addr = 16'hF7FE, bit4 = 1 after release.
- Send a frame with a parity error for 1C → no change. Send a frame with stop bit = 0 → no change. Send a truncated frame (6 bits, then idle past TIMEOUT), then a valid 1C → A pressed.
- Send 11, then 78 → mod = 3'b010 and Fn[11] = 1. Send F0 78 → Fn = 0.
- Press Q (15) and 1 (16), addr = 16'hF3FE (rows 2 and 3) → key_data = 5'b11110. Addr = 16'hFFFE → 11111.
- Apply PS/2 clock glitches shorter than FILTER_LEN → no strobe. Assert reset with keys held → outputs return to reset values asynchronously.
